// File: rtl/csa_subtractor_seq_pkg.sv
// Shared definitions for the chunked carry-skip subtractor: FSM encoding and
// an index-width helper that never returns zero.
package csa_subtractor_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width needed to count 0..n-1, clamped to at least one bit so NCHUNK==1 still has an index.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/csa_sub_chunk.sv
// Combinational CHUNK_W-bit subtract slice: d_c = a_c - b_c - bin, computed as
// a_c + ~b_c + ~bin with a carry-skip bypass around the ripple chain.
module csa_sub_chunk
  import csa_subtractor_seq_pkg::*;
#(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a_c,
  input  logic [CHUNK_W-1:0] b_c,
  input  logic               bin,
  output logic [CHUNK_W-1:0] d_c,
  output logic               bout
);

  logic [CHUNK_W-1:0] b_inv;
  logic [CHUNK_W-1:0] p;
  logic [CHUNK_W-1:0] g;
  logic               cout;

  always_comb begin
    logic carry;
    b_inv = ~b_c;
    p     = a_c ^ b_inv;
    g     = a_c & b_inv;
    d_c   = '0;
    carry = ~bin;
    for (int i = 0; i < CHUNK_W; i++) begin
      d_c[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    // All-propagate chunk: carry-in passes straight through, bypassing the ripple chain.
    cout = (&p) ? ~bin : carry;
    bout = ~cout;
  end

endmodule

// File: rtl/csa_subtractor_seq.sv
// Multi-cycle DATA_W-bit subtractor, one CHUNK_W slice per RUN cycle (LSB first),
// with the borrow registered between chunks and valid/ready on both sides.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for operands
// ST_RUN  | subtracting chunk idx_q, borrow carried in borrow_q
// ST_DONE | out_valid=1, result and flags held until out_ready
module csa_subtractor_seq
  import csa_subtractor_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              ovf,
  output logic              zero
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = clog2_min1(NCHUNK);
  localparam int MSB    = DATA_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (DATA_W % CHUNK_W != 0) begin : g_bad_width
    $error("csa_subtractor_seq: DATA_W must be a multiple of CHUNK_W");
  end

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  diff_q, diff_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [CHUNK_W-1:0] a_c, b_c, d_c;
  logic               chunk_bout;

  assign a_c = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign b_c = b_q[idx_q*CHUNK_W +: CHUNK_W];

  csa_sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a_c  (a_c),
    .b_c  (b_c),
    .bin  (borrow_q),
    .d_c  (d_c),
    .bout (chunk_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          diff_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[idx_q*CHUNK_W +: CHUNK_W] = d_c;
        borrow_d = chunk_bout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Flags come from the fully assembled result, including this cycle's top chunk.
          idx_d   = '0;
          bout_d  = chunk_bout;
          ovf_d   = (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ diff_d[MSB]);
          zero_d  = ~|diff_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csa_subtractor_seq.sv
// Self-checking bench for csa_subtractor_seq (DATA_W=16, CHUNK_W=4): directed
// corner cases plus randomized traffic against an arithmetic reference model.
module tb_csa_subtractor_seq;

  localparam int DATA_W = 16;
  localparam int N_RAND = 3000;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              bin;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] diff;
  logic              bout;
  logic              ovf;
  logic              zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              bo;
    logic              ov;
    logic              z;
  } exp_t;

  exp_t exp_q[$];

  csa_subtractor_seq #(.DATA_W(16), .CHUNK_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [DATA_W-1:0] ma, input logic [DATA_W-1:0] mb,
                                 input logic mbin);
    exp_t e;
    int ur, sr;
    ur   = int'(ma) - int'(mb) - int'(mbin);
    sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    e.d  = ur[DATA_W-1:0];
    e.bo = (ur < 0);
    e.ov = (sr < -32768) || (sr > 32767);
    e.z  = (e.d == '0);
    return e;
  endfunction

  // Drives one operation from IDLE and collects its result; lat = edges from accept to out_valid.
  task automatic do_op(input logic [DATA_W-1:0] ta, input logic [DATA_W-1:0] tb_v, input logic tbin,
                       output exp_t obs, output int lat);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    obs.d = diff; obs.bo = bout; obs.ov = ovf; obs.z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    n_vec++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: diff=%h bout=%b ovf=%b zero=%b, want 0000/0/0/0", diff, bout, ovf, zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [DATA_W-1:0] va[5]  = '{16'h0000, 16'h8000, 16'h1234, 16'h0005, 16'hFFFF};
    logic [DATA_W-1:0] vb[5]  = '{16'h0001, 16'h0001, 16'h1234, 16'h0003, 16'hFFFF};
    logic              vbi[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [DATA_W-1:0] vd[5]  = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};
    logic              vbo[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic              vov[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic              vz[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t obs;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_ready: in_ready=%b, want 1", i, in_ready);
      end
      do_op(va[i], vb[i], vbi[i], obs, lat);
      n_vec++;
      if (lat !== 4) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d cycles, want 4", i, lat);
      end
      n_vec++;
      if (obs.d !== vd[i] || obs.bo !== vbo[i] || obs.ov !== vov[i] || obs.z !== vz[i]) begin
        n_err++;
        $display("FAIL dir%0d_result: diff=%h bout=%b ovf=%b zero=%b, want %h/%b/%b/%b",
                 i, obs.d, obs.bo, obs.ov, obs.z, vd[i], vbo[i], vov[i], vz[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e, held;
    int   lat;
    e = model(16'hA5C3, 16'h3C5A, 1'b1);
    out_ready = 1'b0;
    a = 16'hA5C3; b = 16'h3C5A; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    held.d = diff; held.bo = bout; held.ov = ovf; held.z = zero;
    n_vec++;
    if (lat !== 4 || held.d !== e.d || held.bo !== e.bo || held.ov !== e.ov || held.z !== e.z) begin
      n_err++;
      $display("FAIL bp_result: lat=%0d diff=%h bout=%b ovf=%b zero=%b, want 4 %h/%b/%b/%b",
               lat, held.d, held.bo, held.ov, held.z, e.d, e.bo, e.ov, e.z);
    end
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== held.d || bout !== held.bo ||
          ovf !== held.ov || zero !== held.z) begin
        n_err++;
        $display("FAIL bp_hold%0d: ov=%b ir=%b diff=%h bout=%b ovf=%b zero=%b, want 1/0 %h/%b/%b/%b",
                 i, out_valid, in_ready, diff, bout, ovf, zero, held.d, held.bo, held.ov, held.z);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_no_reaccept: in_ready=%b, want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, obs;
    int   lat;
    int   seen_valid;
    a = 16'h4321; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_run: in_ready=%b out_valid=%b diff=%h, want 1/0/0000", in_ready, out_valid, diff);
    end
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen_valid++;
    end
    n_vec++;
    if (seen_valid !== 0) begin
      n_err++;
      $display("FAIL rst_discard: out_valid seen %0d cycles, want 0", seen_valid);
    end
    e = model(16'h00F0, 16'h0F0F, 1'b1);
    do_op(16'h00F0, 16'h0F0F, 1'b1, obs, lat);
    n_vec++;
    if (lat !== 4 || obs.d !== e.d || obs.bo !== e.bo || obs.ov !== e.ov || obs.z !== e.z) begin
      n_err++;
      $display("FAIL rst_next_op: lat=%0d diff=%h bout=%b ovf=%b zero=%b, want 4 %h/%b/%b/%b",
               lat, obs.d, obs.bo, obs.ov, obs.z, e.d, e.bo, e.ov, e.z);
    end
  endtask

  task automatic test_random();
    int got;
    int cyc;
    exp_q.delete();
    got = 0;
    fork
      begin : drv
        for (int k = 0; k < N_RAND; k++) begin
          int  gap, wt;
          bit  go;
          logic [DATA_W-1:0] ra, rb;
          logic rbi;
          gap = $urandom_range(0, 2);
          repeat (gap) begin
            @(posedge clk); #1;
          end
          case ($urandom_range(0, 4))
            0:       begin ra = 16'($urandom); rb = ra; end
            1:       begin ra = 16'h8000; rb = 16'($urandom); end
            default: begin ra = 16'($urandom); rb = 16'($urandom); end
          endcase
          rbi = 1'($urandom);
          a = ra; b = rb; bin = rbi; in_valid = 1'b1;
          wt = 0;
          go = 1'b0;
          while (!go && wt < 200) begin
            go = in_ready;
            @(posedge clk); #1;
            wt++;
          end
          in_valid = 1'b0;
          if (!go) begin
            n_vec++;
            n_err++;
            $display("FAIL rand_accept_timeout: op %0d not accepted in %0d cycles", k, wt);
            break;
          end
          exp_q.push_back(model(ra, rb, rbi));
        end
      end
      begin : mon
        exp_t e;
        cyc = 0;
        while (got < N_RAND && cyc < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready) begin
            n_vec++;
            got++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL rand_dup: result diff=%h with no op outstanding", diff);
            end else begin
              e = exp_q.pop_front();
              if (diff !== e.d || bout !== e.bo || ovf !== e.ov || zero !== e.z) begin
                n_err++;
                $display("FAIL rand_result%0d: diff=%h bout=%b ovf=%b zero=%b, want %h/%b/%b/%b",
                         got, diff, bout, ovf, zero, e.d, e.bo, e.ov, e.z);
              end
            end
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    n_vec++;
    if (got !== N_RAND || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL rand_count: received %0d results with %0d pending, want %0d and 0",
               got, exp_q.size(), N_RAND);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
